// File: rtl/rs_decoder_18_16.sv
// rtl/rs_decoder_18_16.sv - streaming RS(18,16) single-symbol-error decoder over GF(2^SYMBOL_WIDTH)
//
// Accepts one 18-symbol systematic codeword (highest degree first), forms the
// syndromes S0 = c(1) and S1 = c(alpha) on the fly, locates a single symbol
// error in one solve cycle and streams the 16 corrected message symbols out.
//
// Ports:
//   clk               in   sole clock, rising edge
//   rst_n             in   asynchronous active-low reset
//   in_valid          in   in_sym valid
//   in_ready          out  decoder accepts in_sym (COLLECT only)
//   in_sym            in   received symbol, arrival index i holds degree 17-i
//   out_valid         out  out_sym valid (EMIT only)
//   out_ready         in   downstream accepts out_sym
//   out_sym           out  corrected message symbol
//   out_last          out  16th message symbol of the codeword
//   err_corrected     out  single error located and repaired
//   err_uncorrectable out  error detected but not locatable

`ifndef SYMBOL_WIDTH
`define SYMBOL_WIDTH 8
`endif

module rs_decoder_18_16 #(
    parameter int                        SYMBOL_WIDTH = `SYMBOL_WIDTH,
    // Low bits of the field polynomial; x^8+x^4+x^3+x^2+1 for the 8-bit field.
    parameter logic [SYMBOL_WIDTH-1:0]   GF_POLY      = SYMBOL_WIDTH'('h1D)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SYMBOL_WIDTH-1:0] in_sym,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SYMBOL_WIDTH-1:0] out_sym,
    output logic                    out_last,
    output logic                    err_corrected,
    output logic                    err_uncorrectable
);

    localparam int W = SYMBOL_WIDTH;
    localparam int N = 18;
    localparam int K = 16;

    localparam logic [W-1:0] ALPHA = W'(2);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_SOLVE   = 2'd1;
    localparam logic [1:0] ST_EMIT    = 2'd2;

    // ------------------------------------------------------------------
    // GF arithmetic
    // ------------------------------------------------------------------
    function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] p;
        logic [W-1:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < W; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[W-1] ? ({aa[W-2:0], 1'b0} ^ GF_POLY) : {aa[W-2:0], 1'b0};
        end
        return p;
    endfunction

    // a^(2^W - 2) = a^-1 for a != 0; yields 0 for a == 0.
    function automatic logic [W-1:0] gf_inv(input logic [W-1:0] a);
        logic [W-1:0] r;
        logic [W-1:0] x;
        r = W'(1);
        x = a;
        for (int i = 1; i < W; i++) begin
            x = gf_mul(x, x);
            r = gf_mul(r, x);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] gf_div(input logic [W-1:0] a, input logic [W-1:0] b);
        return gf_mul(a, gf_inv(b));
    endfunction

    // Index lookup: returns k+1 when q == alpha^k for k in 0..N-1, else 0.
    // Only degrees that exist in the codeword are searched, so a miss means
    // the error position lies outside the codeword.
    function automatic logic [4:0] gf_index(input logic [W-1:0] q);
        logic [W-1:0] p;
        logic [4:0]   idx;
        p   = W'(1);
        idx = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == 5'd0 && q == p) idx = 5'(k + 1);
            p = gf_mul(p, ALPHA);
        end
        return idx;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]   state_q,   state_d;
    logic [4:0]   cnt_q,     cnt_d;
    logic [3:0]   rd_q,      rd_d;
    logic [W-1:0] s0_q,      s0_d;
    logic [W-1:0] s1_q,      s1_d;
    logic [4:0]   err_pos_q, err_pos_d;
    logic [W-1:0] err_mag_q, err_mag_d;
    logic         corr_q,    corr_d;
    logic         uncorr_q,  uncorr_d;
    logic [W-1:0] sym_buf_q [N];

    logic         in_fire;
    logic         out_fire;
    logic [W-1:0] q_w;
    logic [4:0]   idx_w;

    assign in_ready  = (state_q == ST_COLLECT);
    assign out_valid = (state_q == ST_EMIT);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    assign q_w   = gf_div(s1_q, s0_q);
    assign idx_w = gf_index(q_w);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        s0_d      = s0_q;
        s1_d      = s1_q;
        err_pos_d = err_pos_q;
        err_mag_d = err_mag_q;
        corr_d    = corr_q;
        uncorr_d  = uncorr_q;

        case (state_q)
            ST_COLLECT: begin
                if (in_fire) begin
                    s0_d  = s0_q ^ in_sym;
                    s1_d  = gf_mul(s1_q, ALPHA) ^ in_sym;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'(N - 1)) state_d = ST_SOLVE;
                end
            end
            ST_SOLVE: begin
                state_d = ST_EMIT;
                if (s0_q == '0 && s1_q == '0) begin
                    corr_d   = 1'b0;
                    uncorr_d = 1'b0;
                end else if (s0_q != '0 && s1_q != '0 && idx_w != 5'd0) begin
                    // j = idx-1 is the error degree; arrival index = 17 - j = 18 - idx.
                    err_pos_d = 5'(N) - idx_w;
                    err_mag_d = s0_q;
                    corr_d    = 1'b1;
                end else begin
                    uncorr_d = 1'b1;
                end
            end
            ST_EMIT: begin
                if (out_fire) begin
                    if (rd_q == 4'(K - 1)) begin
                        state_d  = ST_COLLECT;
                        cnt_d    = '0;
                        rd_d     = '0;
                        s0_d     = '0;
                        s1_d     = '0;
                        corr_d   = 1'b0;
                        uncorr_d = 1'b0;
                    end else begin
                        rd_d = rd_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_COLLECT;
            cnt_q     <= '0;
            rd_q      <= '0;
            s0_q      <= '0;
            s1_q      <= '0;
            err_pos_q <= '0;
            err_mag_q <= '0;
            corr_q    <= 1'b0;
            uncorr_q  <= 1'b0;
            for (int i = 0; i < N; i++) sym_buf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            err_pos_q <= err_pos_d;
            err_mag_q <= err_mag_d;
            corr_q    <= corr_d;
            uncorr_q  <= uncorr_d;
            if (in_fire) sym_buf_q[cnt_q] <= in_sym;
        end
    end

    // Parity-position errors (err_pos 16/17) never match rd, so the message
    // passes through unchanged while err_corrected still reports the repair.
    always_comb begin
        out_sym           = '0;
        out_last          = 1'b0;
        err_corrected     = 1'b0;
        err_uncorrectable = 1'b0;
        if (out_valid) begin
            out_sym = sym_buf_q[{1'b0, rd_q}];
            if (corr_q && ({1'b0, rd_q} == err_pos_q)) out_sym = out_sym ^ err_mag_q;
            out_last          = (rd_q == 4'(K - 1));
            err_corrected     = corr_q;
            err_uncorrectable = uncorr_q;
        end
    end

endmodule

// File: tb/tb_rs_decoder_18_16.sv
// tb/tb_rs_decoder_18_16.sv - directed self-checking bench for rs_decoder_18_16

module tb_rs_decoder_18_16;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_sym;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sym;
    logic       out_last;
    logic       err_corrected;
    logic       err_uncorrectable;

    int checks;
    int errors;

    logic [7:0] tx      [18];
    logic [7:0] exp_sym [16];
    logic [7:0] rx_sym  [16];
    logic       rx_last [16];
    logic       rx_corr [16];
    logic       rx_unc  [16];
    int         rx_n;
    logic       rx_stall_ok;

    rs_decoder_18_16 dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_sym            (in_sym),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_sym           (out_sym),
        .out_last          (out_last),
        .err_corrected     (err_corrected),
        .err_uncorrectable (err_uncorrectable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference GF(256) multiply, polynomial 0x11D, MSB-first.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] acc;
        acc = '0;
        for (int i = 7; i >= 0; i--) begin
            acc = acc << 1;
            if (acc[8]) acc = acc ^ 9'h11D;
            if (b[i]) acc = acc ^ {1'b0, a};
        end
        return acc[7:0];
    endfunction

    // Fill tx with message 0x01..0x10 plus parity so that c(1) = c(alpha) = 0.
    task automatic build_msg_codeword();
        logic [7:0] a;
        logic [7:0] s;
        for (int i = 0; i < 16; i++) tx[i] = 8'(i + 1);
        a = '0;
        for (int i = 0; i < 16; i++) a = a ^ tx[i];
        for (int p1 = 0; p1 < 256; p1++) begin
            tx[16] = 8'(p1);
            tx[17] = a ^ 8'(p1);
            s = '0;
            for (int i = 0; i < 18; i++) s = ref_mul(s, 8'h02) ^ tx[i];
            if (s == 8'h00) break;
        end
        for (int i = 0; i < 16; i++) exp_sym[i] = 8'(i + 1);
    endtask

    task automatic clear_tx();
        for (int i = 0; i < 18; i++) tx[i] = 8'h00;
        for (int i = 0; i < 16; i++) exp_sym[i] = 8'h00;
    endtask

    // Drives tx; leaves a one-cycle idle gap before index gap_at (-1: none).
    // Returns at the falling edge right after the 18th accept.
    task automatic send_cw(input int gap_at);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i == gap_at) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_sym   = tx[i];
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_sym   = 8'h00;
    endtask

    // Records up to nbeats output beats, called on a falling edge. Optionally
    // stalls out_ready for stall_len cycles at stall_beat and notes whether
    // the held beat stayed stable.
    task automatic recv_cw(input int stall_beat, input int stall_len, input int nbeats);
        int budget;
        logic [7:0] held;
        rx_n        = 0;
        budget      = 0;
        rx_stall_ok = 1'b1;
        out_ready   = 1'b1;
        while (rx_n < nbeats && budget < 300) begin
            if (out_valid) begin
                if (rx_n == stall_beat) begin
                    held      = out_sym;
                    out_ready = 1'b0;
                    repeat (stall_len) begin
                        @(negedge clk);
                        if (!out_valid || out_sym !== held || out_last !== 1'b0) rx_stall_ok = 1'b0;
                    end
                    out_ready = 1'b1;
                end
                rx_sym[rx_n]  = out_sym;
                rx_last[rx_n] = out_last;
                rx_corr[rx_n] = err_corrected;
                rx_unc[rx_n]  = err_uncorrectable;
                rx_n++;
            end
            if (rx_n < nbeats) begin
                @(negedge clk);
                budget++;
            end
        end
        if (rx_n == nbeats) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sym    = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_sym, out_last, err_corrected, err_uncorrectable} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b vld=%b sym=%h last=%b c=%b u=%b exp rdy=1 vld=0 sym=00 last=0 c=0 u=0",
                     in_ready, out_valid, out_sym, out_last, err_corrected, err_uncorrectable);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_all_zero();
        clear_tx();
        send_cw(-1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_solve_cycle out_valid got %b exp 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL zero_latency out_valid got %b exp 1", out_valid);
        end
        recv_cw(-1, 0, 16);
        checks++;
        if (rx_n !== 16) begin
            errors++;
            $display("FAIL zero_beats got %0d exp 16", rx_n);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({rx_sym[i], rx_last[i], rx_corr[i], rx_unc[i]} !== {exp_sym[i], (i == 15), 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL zero_beat[%0d] got sym=%h last=%b c=%b u=%b exp sym=%h last=%b c=0 u=0",
                         i, rx_sym[i], rx_last[i], rx_corr[i], rx_unc[i], exp_sym[i], (i == 15));
            end
        end
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL zero_back_to_collect got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_single_msg_error();
        clear_tx();
        tx[3] = 8'h5A;
        send_cw(-1);
        recv_cw(-1, 0, 16);
        checks++;
        if (rx_n !== 16) begin
            errors++;
            $display("FAIL msg_err_beats got %0d exp 16", rx_n);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({rx_sym[i], rx_last[i], rx_corr[i], rx_unc[i]} !== {8'h00, (i == 15), 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL msg_err_beat[%0d] got sym=%h last=%b c=%b u=%b exp sym=00 last=%b c=1 u=0",
                         i, rx_sym[i], rx_last[i], rx_corr[i], rx_unc[i], (i == 15));
            end
        end
    endtask

    task automatic test_single_parity_error();
        clear_tx();
        tx[17] = 8'h80;
        send_cw(-1);
        recv_cw(-1, 0, 16);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({rx_sym[i], rx_corr[i], rx_unc[i]} !== {8'h00, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL par_err_beat[%0d] got sym=%h c=%b u=%b exp sym=00 c=1 u=0",
                         i, rx_sym[i], rx_corr[i], rx_unc[i]);
            end
        end
    endtask

    task automatic test_double_error();
        clear_tx();
        tx[0] = 8'h11;
        tx[5] = 8'h11;
        exp_sym[0] = 8'h11;
        exp_sym[5] = 8'h11;
        send_cw(-1);
        recv_cw(-1, 0, 16);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({rx_sym[i], rx_corr[i], rx_unc[i]} !== {exp_sym[i], 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL dbl_err_beat[%0d] got sym=%h c=%b u=%b exp sym=%h c=0 u=1",
                         i, rx_sym[i], rx_corr[i], rx_unc[i], exp_sym[i]);
            end
        end
    endtask

    // Both syndromes nonzero but S1/S0 = alpha^25, beyond degree 17.
    task automatic test_unlocatable();
        clear_tx();
        tx[16] = 8'h02;
        tx[17] = 8'h01;
        send_cw(-1);
        recv_cw(-1, 0, 16);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({rx_sym[i], rx_corr[i], rx_unc[i]} !== {8'h00, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL unloc_beat[%0d] got sym=%h c=%b u=%b exp sym=00 c=0 u=1",
                         i, rx_sym[i], rx_corr[i], rx_unc[i]);
            end
        end
    endtask

    // Error at arrival index 0 (highest degree) with input gaps.
    task automatic test_first_position_gap();
        build_msg_codeword();
        tx[0] = tx[0] ^ 8'hFF;
        send_cw(6);
        recv_cw(-1, 0, 16);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({rx_sym[i], rx_corr[i], rx_unc[i]} !== {exp_sym[i], 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL pos0_beat[%0d] got sym=%h c=%b u=%b exp sym=%h c=1 u=0",
                         i, rx_sym[i], rx_corr[i], rx_unc[i], exp_sym[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        build_msg_codeword();
        send_cw(-1);
        recv_cw(7, 5, 16);
        checks++;
        if (rx_stall_ok !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold got stable=%b exp 1", rx_stall_ok);
        end
        checks++;
        if (rx_n !== 16) begin
            errors++;
            $display("FAIL bp_beats got %0d exp 16", rx_n);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({rx_sym[i], rx_last[i], rx_corr[i], rx_unc[i]} !== {exp_sym[i], (i == 15), 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL bp_beat[%0d] got sym=%h last=%b c=%b u=%b exp sym=%h last=%b c=0 u=0",
                         i, rx_sym[i], rx_last[i], rx_corr[i], rx_unc[i], exp_sym[i], (i == 15));
            end
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_dup out_valid got %b exp 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        build_msg_codeword();
        tx[9] = tx[9] ^ 8'h33;
        send_cw(-1);
        recv_cw(-1, 0, 4);
        checks++;
        if ({out_valid, out_sym, err_corrected} !== {1'b1, 8'h05, 1'b1}) begin
            errors++;
            $display("FAIL mid_pre_reset got vld=%b sym=%h c=%b exp vld=1 sym=05 c=1",
                     out_valid, out_sym, err_corrected);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_sym, out_last, err_corrected, err_uncorrectable} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset_outputs got rdy=%b vld=%b sym=%h last=%b c=%b u=%b exp rdy=1 vld=0 sym=00 last=0 c=0 u=0",
                     in_ready, out_valid, out_sym, out_last, err_corrected, err_uncorrectable);
        end
        @(negedge clk);
        rst_n = 1'b1;
        build_msg_codeword();
        send_cw(-1);
        recv_cw(-1, 0, 16);
        checks++;
        if (rx_n !== 16) begin
            errors++;
            $display("FAIL mid_after_beats got %0d exp 16", rx_n);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({rx_sym[i], rx_last[i], rx_corr[i], rx_unc[i]} !== {exp_sym[i], (i == 15), 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL mid_after_beat[%0d] got sym=%h last=%b c=%b u=%b exp sym=%h last=%b c=0 u=0",
                         i, rx_sym[i], rx_last[i], rx_corr[i], rx_unc[i], exp_sym[i], (i == 15));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_all_zero();
        test_single_msg_error();
        test_single_parity_error();
        test_double_error();
        test_unlocatable();
        test_first_position_gap();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
